// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, field positions and opcode encodings for the fetch front end.
// Everything that decodes an instruction word imports these instead of hard-coding them.
package inst_fetch_unit_pkg;

    localparam int W_PC     = 12;
    localparam int W_INST   = 32;
    localparam int RESET_PC = 0;

    // Opcode field of an instruction word.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int W_OPC   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [W_OPC-1:0] {
        OPC_ALU  = 5'b00000,
        OPC_J    = 5'b00001,
        OPC_BNE  = 5'b00010,
        OPC_JAL  = 5'b00011,
        OPC_JR   = 5'b00100,
        OPC_ADDI = 5'b00101,
        OPC_BLT  = 5'b00110,
        OPC_SW   = 5'b00111,
        OPC_LW   = 5'b01000,
        OPC_SETX = 5'b10101,
        OPC_BEX  = 5'b10110
    } opcode_e;

endpackage

// File: rtl/inst_fetch_unit_skid_fifo.sv
// Two-entry {inst, pc} skid FIFO that catches ROM responses while decode is stalled.
// Entry 0 is always the head, so the head output needs no read pointer.
module fetch_skid_fifo #(
    parameter int W = 44
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= din;
                    else               mem1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                // Push and pop together: shift the tail forward, occupancy unchanged.
                2'b11: begin
                    if (count == 2'd2) begin
                        mem0 <= mem1;
                        mem1 <= din;
                    end else begin
                        mem0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = mem0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, ROM request issue, skid buffering and redirect squash.
// A response bypasses the FIFO straight to decode when the FIFO is empty.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int W_PC     = inst_fetch_unit_pkg::W_PC,
    parameter int W_INST   = inst_fetch_unit_pkg::W_INST,
    parameter int RESET_PC = inst_fetch_unit_pkg::RESET_PC
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [W_PC-1:0]   imem_addr,
    output logic              imem_en,
    input  logic [W_INST-1:0] imem_q,
    input  logic              redirect_valid,
    input  logic [W_PC-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [W_INST-1:0] inst,
    output logic [W_PC-1:0]   inst_pc,
    output logic [W_OPC-1:0]  inst_opcode
);

    localparam int W_E = W_INST + W_PC;

    logic [W_PC-1:0] fetch_pc;
    logic [W_PC-1:0] infl_pc_q;
    logic            infl_q;
    logic [1:0]      count;
    logic [W_E-1:0]  fifo_head;
    logic            pop;
    logic            issue;
    logic            push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [2:0]      occ;

    assign imem_addr  = redirect_valid ? redirect_pc : fetch_pc;
    assign fifo_empty = (count == 2'd0);
    assign inst_valid = (!fifo_empty || infl_q) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    // Words held after this cycle, ignoring the request we might issue now.
    assign occ   = {1'b0, count} + {2'b00, infl_q} - {2'b00, pop};
    assign issue = redirect_valid || (occ <= 3'd1);
    // No request leaves while reset is held, even though issue is already high.
    assign imem_en = issue && reset_n;

    // A response is squashed on redirect and skips the FIFO when decode takes it via bypass.
    assign push     = infl_q && !redirect_valid && !(fifo_empty && pop);
    assign fifo_pop = pop && !fifo_empty;

    assign {inst, inst_pc} = fifo_empty ? {imem_q, infl_pc_q} : fifo_head;
    assign inst_opcode     = inst[OPC_MSB:OPC_LSB];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc  <= W_PC'(RESET_PC);
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            infl_q    <= issue;
            infl_pc_q <= imem_addr;
            if (issue) fetch_pc <= imem_addr + W_PC'(1);
        end
    end

    fetch_skid_fifo #(.W(W_E)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (fifo_pop),
        .flush   (redirect_valid),
        .din     ({imem_q, infl_pc_q}),
        .head    (fifo_head),
        .count   (count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: behavioural 1-cycle ROM, directed phases, scoreboard monitor.
// ROM word at address A is {A[4:0], 27'(A)}, so every accepted word identifies its own PC.
module tb_inst_fetch_unit;

    localparam int W_PC   = 12;
    localparam int W_INST = 32;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [W_PC-1:0]   imem_addr;
    logic              imem_en;
    logic [W_INST-1:0] imem_q = '0;
    logic              redirect_valid;
    logic [W_PC-1:0]   redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [W_INST-1:0] inst;
    logic [W_PC-1:0]   inst_pc;
    logic [4:0]        inst_opcode;

    int checks = 0;
    int errors = 0;

    logic [W_PC-1:0] exp_q[$];

    logic              prev_stall = 1'b0;
    logic [W_PC-1:0]   hold_pc    = '0;
    logic [W_INST-1:0] hold_inst  = '0;

    inst_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode)
    );

    // ---------------- clock / reset / ROM ----------------
    always #5 clock = ~clock;

    function automatic logic [W_INST-1:0] rom_word(input logic [W_PC-1:0] a);
        return {a[4:0], 15'b0, a};
    endfunction

    always @(posedge clock) begin
        if (imem_en) imem_q <= rom_word(imem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic load_exp(input logic [W_PC-1:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + W_PC'(i));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [W_PC-1:0] e;
        if (reset_n) begin
            if (redirect_valid) chk("valid_during_redirect", 32'(inst_valid), 32'd0);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept act=%h exp=none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_pc", 32'(inst_pc), 32'(e));
                    chk("acc_inst", inst, rom_word(e));
                    chk("acc_opcode", 32'(inst_opcode), 32'(e[4:0]));
                end
            end
            if (prev_stall) begin
                if (inst_valid) begin
                    chk("stall_hold_pc", 32'(inst_pc), 32'(hold_pc));
                    chk("stall_hold_inst", inst, hold_inst);
                end else if (!redirect_valid) begin
                    chk("stall_dropped", 32'(inst_valid), 32'd1);
                end
            end
        end
        prev_stall = reset_n && inst_valid && !inst_ready;
        hold_pc    = inst_pc;
        hold_inst  = inst;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n        = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        load_exp(12'h000, 64);

        // Reset state.
        repeat (3) @(posedge clock);
        sample();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h000);

        // Release: first request in cycle 1, first word valid in cycle 2.
        step();
        reset_n = 1'b1;
        sample();
        chk("c1_valid", 32'(inst_valid), 32'd0);
        chk("c1_en", 32'(imem_en), 32'd1);
        chk("c1_addr", 32'(imem_addr), 32'h000);
        step();
        sample();
        chk("c2_valid", 32'(inst_valid), 32'd1);
        chk("c2_pc", 32'(inst_pc), 32'h000);

        // Stall with pc 4 at the head for five cycles.
        repeat (3) step();
        step();
        inst_ready = 1'b0;
        sample();
        chk("stall_head_valid", 32'(inst_valid), 32'd1);
        chk("stall_head_pc", 32'(inst_pc), 32'h004);
        for (int i = 1; i < 5; i++) begin
            step();
            sample();
            chk("stall_pc", 32'(inst_pc), 32'h004);
            chk("stall_en_low", 32'(imem_en), 32'd0);
        end

        // Release: 4,5,6,7 back to back.
        step();
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("drain_valid", 32'(inst_valid), 32'd1);
            chk("drain_pc", 32'(inst_pc), 32'(4 + i));
            step();
        end

        // Fill the skid buffer, then redirect to 0x40.
        inst_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 12'h040;
        inst_ready     = 1'b1;
        load_exp(12'h040, 64);
        sample();
        chk("redir_valid", 32'(inst_valid), 32'd0);
        chk("redir_en", 32'(imem_en), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h040);
        step();
        redirect_valid = 1'b0;
        sample();
        chk("redir_tgt_valid", 32'(inst_valid), 32'd1);
        chk("redir_tgt_pc", 32'(inst_pc), 32'h040);
        step();
        sample();
        chk("redir_next_pc", 32'(inst_pc), 32'h041);

        // Wrap at the top of the address space.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFF;
        load_exp(12'hFFF, 64);
        step();
        redirect_valid = 1'b0;
        sample();
        chk("wrap_top_pc", 32'(inst_pc), 32'hFFF);
        step();
        sample();
        chk("wrap_zero_pc", 32'(inst_pc), 32'h000);

        // Back-to-back redirects: the second one wins.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 12'h100;
        load_exp(12'h100, 64);
        step();
        redirect_pc    = 12'h200;
        load_exp(12'h200, 64);
        step();
        redirect_valid = 1'b0;
        sample();
        chk("dbl_redir_pc", 32'(inst_pc), 32'h200);
        step();
        sample();
        chk("dbl_redir_next", 32'(inst_pc), 32'h201);

        // Asynchronous reset with a full skid buffer.
        step();
        inst_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_en", 32'(imem_en), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'h000);
        load_exp(12'h000, 64);
        step();
        step();
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        sample();
        chk("post_rst_c1_valid", 32'(inst_valid), 32'd0);
        step();
        sample();
        chk("post_rst_pc", 32'(inst_pc), 32'h000);

        // Random ready and redirects; the scoreboard tracks the PC stream.
        for (int i = 0; i < 200; i++) begin
            step();
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = W_PC'($urandom_range(0, 4095));
                load_exp(redirect_pc, 256);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (5) step();
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
